// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced key front end and run/pause/done FSM
// driving an external stopwatch counter (run, clear_n, finish).
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       key_finish_n,
    output logic       run,
    output logic       clear_n,
    output logic       finish,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // key index: 0 start, 1 clear, 2 finish
    logic [2:0]    keys_n;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    prev;
    logic [2:0]    armed;
    logic [2:0]    evt;
    logic [CW-1:0] cnt     [3];
    logic [CW-1:0] arm_cnt [3];

    state_t cur;
    state_t nxt;
    logic   clr_acc;

    assign keys_n = {key_finish_n, key_clear_n, key_start_n};
    assign state  = cur;

    // two-flop synchronizers, released (1) out of reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= keys_n;
            sync2 <= sync1;
        end
    end

    // debounce, press-edge detect; a key must be seen stably released
    // after reset before its presses are honoured
    always_ff @(posedge clock) begin
        if (reset) begin
            deb   <= '1;
            prev  <= '1;
            armed <= '0;
            evt   <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i]     <= '0;
                arm_cnt[i] <= '0;
            end
        end else begin
            prev <= deb;
            evt  <= prev & ~deb & armed;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end

                if (armed[i] || !(sync2[i] && deb[i])) begin
                    arm_cnt[i] <= '0;
                end else if (arm_cnt[i] == LAST) begin
                    armed[i]   <= 1'b1;
                    arm_cnt[i] <= '0;
                end else begin
                    arm_cnt[i] <= arm_cnt[i] + 1'b1;
                end
            end
        end
    end

    // next state with clear > finish > start priority
    always_comb begin
        nxt     = cur;
        clr_acc = 1'b0;
        if (evt[1]) begin
            nxt     = IDLE;
            clr_acc = 1'b1;
        end else if (evt[2]) begin
            nxt = DONE;
        end else if (evt[0]) begin
            unique case (cur)
                IDLE:    nxt = RUN;
                RUN:     nxt = PAUSE;
                PAUSE:   nxt = RUN;
                DONE:    nxt = DONE;
                default: nxt = IDLE;
            endcase
        end
    end

    // state and registered outputs; clear_n held low through reset
    always_ff @(posedge clock) begin
        if (reset) begin
            cur     <= IDLE;
            run     <= 1'b0;
            finish  <= 1'b0;
            clear_n <= 1'b0;
        end else begin
            cur     <= nxt;
            run     <= (nxt == RUN);
            finish  <= (nxt == DONE);
            clear_n <= ~clr_acc;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of stopwatch_ctrl with
// DEBOUNCE_CYCLES=4 (press reaches the FSM 7 edges after first sample).
module tb_stopwatch_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ks = 1'b1;
    logic       kc = 1'b1;
    logic       kf = 1'b1;
    logic       run;
    logic       clear_n;
    logic       finish;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int clr_pulses = 0;
    int fin_seen = 0;
    int trans = 0;
    logic [1:0] last_state = 2'd0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .key_start_n  (ks),
        .key_clear_n  (kc),
        .key_finish_n (kf),
        .run          (run),
        .clear_n      (clear_n),
        .finish       (finish),
        .state        (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (!clear_n) clr_pulses++;
        if (finish) fin_seen++;
        if (state != last_state) trans++;
        last_state = state;
    endtask

    task automatic clr_mon();
        clr_pulses = 0;
        fin_seen   = 0;
        trans      = 0;
        last_state = state;
    endtask

    // mask bit 0 start, 1 clear, 2 finish
    task automatic press(input logic [2:0] mask, input int hold);
        if (mask[0]) ks = 1'b0;
        if (mask[1]) kc = 1'b0;
        if (mask[2]) kf = 1'b0;
        repeat (hold) tick();
        ks = 1'b1;
        kc = 1'b1;
        kf = 1'b1;
        repeat (14) tick();
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_run", run, 0);
        chk("rst_finish", finish, 0);
        chk("rst_clear_n", clear_n, 0);
        reset = 1'b0;
        tick();
        chk("rel_clear_n", clear_n, 1);
        repeat (10) tick();

        // start latency: update on the 8th edge counting the sampling one
        ks = 1'b0;
        repeat (7) tick();
        chk("lat_state_early", state, 0);
        chk("lat_run_early", run, 0);
        tick();
        chk("lat_state", state, 1);
        chk("lat_run", run, 1);
        repeat (12) tick();
        ks = 1'b1;
        repeat (14) tick();
        chk("held_state", state, 1);
        press(3'b001, 10);
        chk("pause_state", state, 2);
        chk("pause_run", run, 0);

        // RUN -> DONE, start ignored, clear pulse
        press(3'b001, 10);
        chk("rerun_state", state, 1);
        press(3'b100, 10);
        chk("done_state", state, 3);
        chk("done_finish", finish, 1);
        chk("done_run", run, 0);
        press(3'b001, 10);
        chk("done_start_ign", state, 3);
        clr_mon();
        press(3'b010, 10);
        chk("clr_state", state, 0);
        chk("clr_finish", finish, 0);
        chk("clr_pulses", clr_pulses, 1);
        chk("clr_n_after", clear_n, 1);

        // glitches shorter than the debounce window
        clr_mon();
        for (int r = 0; r < 5; r++) begin
            ks = 1'b0;
            repeat (3) tick();
            ks = 1'b1;
            repeat (2) tick();
        end
        repeat (12) tick();
        chk("glitch_state", state, 0);
        chk("glitch_run", run, 0);
        chk("glitch_trans", trans, 0);

        // simultaneous clear + finish in RUN
        press(3'b001, 10);
        chk("cf_pre_state", state, 1);
        clr_mon();
        press(3'b110, 10);
        chk("cf_state", state, 0);
        chk("cf_pulses", clr_pulses, 1);
        chk("cf_finish_seen", fin_seen, 0);

        // reset mid-debounce while paused with start held
        press(3'b001, 10);
        press(3'b001, 10);
        chk("rp_pause", state, 2);
        ks = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rp_clear_n_rst", clear_n, 0);
        tick();
        chk("rp_clear_n_rst2", clear_n, 0);
        reset = 1'b0;
        tick();
        chk("rp_state_rel", state, 0);
        chk("rp_clear_n_rel", clear_n, 1);
        clr_mon();
        repeat (30) tick();
        chk("rp_held_trans", trans, 0);
        chk("rp_held_run", run, 0);
        ks = 1'b1;
        repeat (14) tick();
        chk("rp_rel_state", state, 0);
        press(3'b001, 10);
        chk("rp_repress", state, 1);

        // long hold from IDLE gives exactly one transition
        press(3'b010, 10);
        chk("lh_idle", state, 0);
        clr_mon();
        press(3'b001, 50);
        chk("lh_state", state, 1);
        chk("lh_trans", trans, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable cycles (20 ms at 50 MHz) before a key level is accepted.
REQ-002 SHALL have port clock  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_start_n  input  1  raw start/stop push button, active-low, asynchronous to clock.
REQ-005 SHALL have port key_clear_n  input  1  raw clear push button, active-low, asynchronous.
REQ-006 SHALL have port key_finish_n  input  1  raw finish push button, active-low, asynchronous.
REQ-007 SHALL have port run  output  1  count enable; drives the stopwatch counter's switch input.
REQ-008 SHALL have port clear_n  output  1  active-low clear; drives the stopwatch counter's reset input.
REQ-009 SHALL have port finish  output  1  finish flag; drives the stopwatch counter's finish input.
REQ-010 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-011 SHALL pass each key through its own 2-flop synchronizer; the synchronizer flops reset to 1 (released).
REQ-012 SHALL keep one debounced level per key, plus a counter wide enough for DEBOUNCE_CYCLES.
REQ-013 SHALL clear a key's counter on any cycle where its synchronized level equals its debounced level.
REQ-014 SHALL increment a key's counter while the levels differ, and load the synchronized level into the debounced level once the mismatch has lasted DEBOUNCE_CYCLES consecutive cycles; the counter then clears.
REQ-015 SHALL treat a glitch shorter than DEBOUNCE_CYCLES cycles as no change.
REQ-016 SHALL generate a one-cycle press event on a debounced 1->0 transition only; releases generate no event.
REQ-017 SHALL update state, run, finish and clear_n exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples a clean key press.
REQ-018 SHALL, when more than one press event falls in the same cycle, resolve them by priority clear > finish > start; lower-priority events in that cycle are discarded.
REQ-019 SHALL use these IDLE transitions: start -> RUN; finish -> DONE; clear -> IDLE.
REQ-020 SHALL use these RUN transitions: start -> PAUSE; finish -> DONE; clear -> IDLE.
REQ-021 SHALL use these PAUSE transitions: start -> RUN; finish -> DONE; clear -> IDLE.
REQ-022 SHALL use these DONE transitions: clear -> IDLE; start and finish ignored (remain DONE).
REQ-023 SHALL register all outputs.
REQ-024 SHALL drive run=1 only in RUN and finish=1 only in DONE.
REQ-025 SHALL drive clear_n=0 for exactly one cycle, coincident with the state update, on every accepted clear event from any state (including IDLE->IDLE); otherwise clear_n=1.
REQ-026 SHALL accept no new event from a key that is held down; a new press requires a debounced release first.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, force state=IDLE, run=0, finish=0, clear_n=0, all debounced levels=1, all counters=0 and all synchronizers=1.
REQ-028 SHALL drive clear_n=1 from the first edge with reset=0, so the downstream counter is held cleared during reset.
REQ-029 SHALL, when reset is asserted mid-debounce or mid-run, abort any pending key event; a key still held at reset release produces no event until released and re-pressed.

Verification (DEBOUNCE_CYCLES=4 for all scenarios)
REQ-030 Reset then clean key_start_n low held 20 cycles -> state=1 and run=1 exactly 7 edges after the first sampling edge; releasing and re-pressing -> state=2, run=0.
REQ-031 key_start_n low pulses of 3 cycles, repeated with 2-cycle high gaps -> no event; state stays 0, run stays 0.
REQ-032 In RUN, press key_finish_n -> state=3, finish=1, run=0; then press start -> no change; then press clear -> state=0, finish=0, clear_n=0 for exactly 1 cycle.
REQ-033 In RUN, press key_clear_n and key_finish_n on the same cycle -> state=0, one clear_n pulse, finish stays 0.
REQ-034 Assert reset for 2 cycles while in PAUSE with key_start_n held low -> clear_n=0 during reset, state=0 after release, no RUN transition until key released and re-pressed.
REQ-035 Hold key_start_n low 50 cycles in IDLE -> exactly one transition to RUN; no toggle back to PAUSE.
